// File: rtl/tqvp_htfab_vga_capture.sv
// TinyQV peripheral: captures a down-sampled 32x14 monochrome frame from a VGA
// input into CPU-readable registers and measures the hsync line period.
//
// state       | meaning
// IDLE        | not capturing, waiting for an arm command
// WAIT_VSYNC  | armed, waiting for the vsync edge that starts a frame
// CAPTURE     | counting lines, sampling pixels of selected lines into rows

module tqvp_htfab_vga_capture #(
  parameter int NUM_ROWS = 14,
  parameter int MEAS_W   = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  ui_in,
  output logic [7:0]  uo_out,
  input  logic [5:0]  address,
  input  logic [31:0] data_in,
  input  logic [1:0]  data_write_n,
  input  logic [1:0]  data_read_n,
  output logic [31:0] data_out,
  output logic        data_ready,
  output logic        user_interrupt
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT_VSYNC, S_CAPTURE} state_t;

  localparam logic [31:0] CFG_DEFAULT = {6'd34, 9'd35, 6'd51, 11'd391};
  localparam logic [3:0]  ROWS        = 4'(NUM_ROWS);
  localparam logic [3:0]  LAST_ROW    = 4'(NUM_ROWS - 1);

  state_t            state_q, state_d;
  logic              cont_q, cont_d;
  logic [3:0]        row_q, row_d;
  logic [8:0]        ycnt_q, ycnt_d;
  logic              sampling_q, sampling_d;
  logic [10:0]       timer_q, timer_d;
  logic [4:0]        bit_q, bit_d;
  logic [31:0]       asm_q, asm_d;
  logic [31:0]       rows_q [NUM_ROWS];
  logic [31:0]       cfg_q;
  logic              done_q, done_d, short_q, short_d, sync_seen_q;
  logic              hs_prev_q, vs_prev_q;
  logic [MEAS_W-1:0] cnt_q, cnt_d, line_period_q;
  logic              data_ready_q;
  logic [31:0]       data_out_q;

  logic        pix, hs_edge, vs_edge, busy;
  logic [3:0]  word;
  logic        cfg_wr, ctrl_wr, ctrl_stop, ctrl_clr, arm_go;
  logic [10:0] x_off;
  logic [5:0]  x_stepm1, y_stepm1;
  logic [8:0]  y_off, ycur;
  logic        line_start, first_line, line_sel, frame_end;
  logic        commit, done_set, short_set, strobe;
  logic [31:0] commit_data, sample_word;
  logic [31:0] status, rd_val, rd_masked;
  logic        rd_req;
  logic        unused_bits;

  assign pix     = ui_in[0];
  assign hs_edge = hs_prev_q & ~ui_in[1];
  assign vs_edge = vs_prev_q & ~ui_in[2];
  assign busy    = (state_q != S_IDLE);
  assign word    = address[5:2];

  assign cfg_wr    = (data_write_n == 2'b10) && (word == 4'd14);
  assign ctrl_wr   = (data_write_n == 2'b10) && (word == 4'd15);
  assign ctrl_stop = ctrl_wr && data_in[3];
  assign ctrl_clr  = ctrl_wr && data_in[2];
  assign arm_go    = ctrl_wr && (data_in[0] || data_in[1]) && !data_in[3];

  // A step field of 0 wraps to 63 here, i.e. a step of 64.
  assign x_off    = cfg_q[10:0];
  assign x_stepm1 = cfg_q[16:11] - 6'd1;
  assign y_off    = cfg_q[25:17];
  assign y_stepm1 = cfg_q[31:26] - 6'd1;

  assign sample_word = asm_q | (32'(pix) << bit_q);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    ycnt_d      = ycnt_q;
    sampling_d  = sampling_q;
    timer_d     = timer_q;
    bit_d       = bit_q;
    asm_d       = asm_q;
    commit      = 1'b0;
    commit_data = asm_q;
    done_set    = 1'b0;
    short_set   = 1'b0;
    strobe      = 1'b0;
    line_start  = 1'b0;
    first_line  = 1'b0;
    frame_end   = 1'b0;
    ycur        = '0;
    line_sel    = 1'b0;

    case (state_q)
      S_WAIT_VSYNC: begin
        if (vs_edge) begin
          state_d    = S_CAPTURE;
          row_d      = '0;
          line_start = 1'b1;
          first_line = 1'b1;
        end
      end
      S_CAPTURE: begin
        if (vs_edge) begin
          commit     = sampling_q;
          done_set   = 1'b1;
          short_set  = 1'b1;
          sampling_d = 1'b0;
          row_d      = '0;
          if (cont_q) begin
            line_start = 1'b1;
            first_line = 1'b1;
          end else begin
            state_d = S_IDLE;
          end
        end else if (hs_edge) begin
          // A line cut short by the next hsync still commits what it has.
          commit = sampling_q;
          if (sampling_q && row_q == LAST_ROW) begin
            frame_end = 1'b1;
          end else begin
            line_start = 1'b1;
            if (sampling_q) row_d = row_q + 4'd1;
          end
        end else if (sampling_q) begin
          if (timer_q == '0) begin
            strobe      = 1'b1;
            asm_d       = sample_word;
            commit_data = sample_word;
            if (bit_q == 5'd31) begin
              commit     = 1'b1;
              sampling_d = 1'b0;
              if (row_q == LAST_ROW) frame_end = 1'b1;
              else row_d = row_q + 4'd1;
            end else begin
              bit_d   = bit_q + 5'd1;
              timer_d = {5'b0, x_stepm1};
            end
          end else begin
            timer_d = timer_q - 11'd1;
          end
        end
      end
      default: ;
    endcase

    if (line_start) begin
      ycur       = first_line ? y_off : ycnt_q;
      line_sel   = (ycur == '0);
      ycnt_d     = line_sel ? {3'b0, y_stepm1} : ycur - 9'd1;
      sampling_d = line_sel;
      asm_d      = '0;
      bit_d      = '0;
      if (line_sel) begin
        // Zero offset means the first sample lands on the hsync edge itself.
        if (x_off == '0) begin
          strobe  = 1'b1;
          asm_d   = {31'b0, pix};
          bit_d   = 5'd1;
          timer_d = {5'b0, x_stepm1};
        end else begin
          timer_d = x_off - 11'd1;
        end
      end
    end

    if (frame_end) begin
      done_set   = 1'b1;
      sampling_d = 1'b0;
      row_d      = '0;
      state_d    = cont_q ? S_WAIT_VSYNC : S_IDLE;
    end

    if (ctrl_stop) begin
      state_d    = S_IDLE;
      sampling_d = 1'b0;
    end else if (arm_go) begin
      state_d    = S_WAIT_VSYNC;
      row_d      = '0;
      sampling_d = 1'b0;
    end
  end

  assign cont_d  = arm_go ? data_in[1] : cont_q;
  assign done_d  = done_set  ? 1'b1 : ((ctrl_clr || arm_go) ? 1'b0 : done_q);
  assign short_d = short_set ? 1'b1 : ((ctrl_clr || arm_go) ? 1'b0 : short_q);
  assign cnt_d   = hs_edge ? MEAS_W'(1) : ((&cnt_q) ? cnt_q : cnt_q + MEAS_W'(1));

  assign status = {16'(line_period_q), 12'b0, short_q, sync_seen_q, done_q, busy};
  assign rd_req = (data_read_n != 2'b11) && !data_ready_q;

  always_comb begin
    rd_val = '0;
    if (word < ROWS) rd_val = rows_q[word];
    else if (word == 4'd14) rd_val = cfg_q;
    else if (word == 4'd15) rd_val = status;
    case (data_read_n)
      2'b00:   rd_masked = rd_val & 32'h0000_00FF;
      2'b01:   rd_masked = rd_val & 32'h0000_FFFF;
      default: rd_masked = rd_val;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      cont_q        <= 1'b0;
      row_q         <= '0;
      ycnt_q        <= '0;
      sampling_q    <= 1'b0;
      timer_q       <= '0;
      bit_q         <= '0;
      asm_q         <= '0;
      for (int i = 0; i < NUM_ROWS; i++) rows_q[i] <= '0;
      cfg_q         <= CFG_DEFAULT;
      done_q        <= 1'b0;
      short_q       <= 1'b0;
      sync_seen_q   <= 1'b0;
      hs_prev_q     <= 1'b0;
      vs_prev_q     <= 1'b0;
      cnt_q         <= '0;
      line_period_q <= '0;
      data_ready_q  <= 1'b0;
      data_out_q    <= '0;
    end else begin
      state_q    <= state_d;
      cont_q     <= cont_d;
      row_q      <= row_d;
      ycnt_q     <= ycnt_d;
      sampling_q <= sampling_d;
      timer_q    <= timer_d;
      bit_q      <= bit_d;
      asm_q      <= asm_d;
      if (commit) rows_q[row_q] <= commit_data;
      if (cfg_wr) cfg_q <= data_in;
      done_q     <= done_d;
      short_q    <= short_d;
      if (vs_edge) sync_seen_q <= 1'b1;
      hs_prev_q  <= ui_in[1];
      vs_prev_q  <= ui_in[2];
      cnt_q      <= cnt_d;
      if (hs_edge) line_period_q <= cnt_q;
      data_ready_q <= rd_req;
      if (rd_req) data_out_q <= rd_masked;
    end
  end

  assign uo_out         = rst_n ? {6'b0, strobe, busy} : 8'h00;
  assign data_out       = data_out_q;
  assign data_ready     = data_ready_q;
  assign user_interrupt = done_q;

  assign unused_bits = ^{address[1:0], ui_in[7:3]};

endmodule

// File: tb/tb_tqvp_htfab_vga_capture.sv
// Bench for tqvp_htfab_vga_capture: drives synthetic VGA frames and compares
// captured rows, strobes and status against an arithmetic sampling model.

module tb_tqvp_htfab_vga_capture;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  ui_in, uo_out;
  logic [5:0]  address;
  logic [31:0] data_in, data_out;
  logic [1:0]  data_write_n, data_read_n;
  logic        data_ready, user_interrupt;

  tqvp_htfab_vga_capture dut (
    .clk(clk), .rst_n(rst_n), .ui_in(ui_in), .uo_out(uo_out),
    .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready),
    .user_interrupt(user_interrupt)
  );

  always #5 clk = ~clk;

  localparam logic [31:0] DEF_CFG = {6'd34, 9'd35, 6'd51, 11'd391};

  int total = 0;
  int bad = 0;
  int pix_mode;
  int unsigned pix_seed;
  int cxo, cxs, cyo, cys;
  bit chk_strobe = 0;
  int strobe_err, strobe_cnt;
  logic [31:0] exp_rows [14];
  logic [31:0] d;
  bit ok;

  function automatic bit pix_f(int line, int t);
    int unsigned h;
    case (pix_mode)
      0: return (t >= 366 && t < 1180);
      1: return (t >= 10 && t % 2 == 0);
      default: begin
        h = pix_seed ^ (32'(line) * 32'h9E3779B1) ^ (32'(t) * 32'h85EBCA6B);
        h = h ^ (h >> 15);
        h = h * 32'h2C1B3C6D;
        h = h ^ (h >> 12);
        return h[9];
      end
    endcase
  endfunction

  function automatic logic [31:0] model_row(int line, int len);
    logic [31:0] r = '0;
    for (int k = 0; k < 32; k++) begin
      int tt = cxo + k * cxs;
      if (tt < len) r[k] = pix_f(line, tt);
    end
    return r;
  endfunction

  function automatic bit exp_strobe(int line, int t);
    int li, ti;
    if (line < cyo || t < cxo) return 0;
    li = line - cyo;
    ti = t - cxo;
    return (li % cys == 0) && (li / cys < 14) && (ti % cxs == 0) && (ti / cxs < 32);
  endfunction

  function automatic logic [31:0] stat(int lp, bit sh, bit sync, bit done, bit busy);
    return {16'(lp), 12'b0, sh, sync, done, busy};
  endfunction

  task automatic fill_model(int nlines, int len);
    for (int r = 0; r < 14; r++) begin
      int line = cyo + r * cys;
      if (line < nlines) exp_rows[r] = model_row(line, len);
    end
  endtask

  task automatic idle(int n);
    ui_in = 8'h06;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic bus_write(int word, logic [31:0] val);
    address = 6'(word * 4);
    data_in = val;
    data_write_n = 2'b10;
    @(posedge clk); #1;
    data_write_n = 2'b11;
  endtask

  task automatic bus_read(int word, logic [1:0] sz, output logic [31:0] val, output bit hs_ok);
    logic r0, r1, r2;
    address = 6'(word * 4);
    data_read_n = sz;
    r0 = data_ready;
    @(posedge clk); #1;
    data_read_n = 2'b11;
    r1 = data_ready;
    val = data_out;
    @(posedge clk); #1;
    r2 = data_ready;
    hs_ok = !r0 && r1 && !r2;
  endtask

  task automatic set_cfg(int xo, int xs, int yo, int ys);
    bus_write(14, {6'(ys), 9'(yo), 6'(xs), 11'(xo)});
    cxo = xo; cxs = (xs == 0) ? 64 : xs;
    cyo = yo; cys = (ys == 0) ? 64 : ys;
  endtask

  task automatic run_frame(int nlines, int len, int hs_len, int vs_n);
    for (int l = 0; l < nlines; l++) begin
      for (int t = 0; t < len; t++) begin
        ui_in = {5'b0, l >= vs_n, t >= hs_len, pix_f(l, t)};
        #1;
        if (chk_strobe) begin
          if (uo_out[1] !== exp_strobe(l, t)) strobe_err++;
          if (uo_out[1]) strobe_cnt++;
        end
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic check_rows(string tag);
    for (int r = 0; r < 14; r++) begin
      bus_read(r, 2'b10, d, ok);
      total++;
      if (d !== exp_rows[r]) begin
        bad++;
        $display("FAIL %s row%0d: got %h want %h", tag, r, d, exp_rows[r]);
      end
    end
  endtask

  task automatic check_status(string tag, logic [31:0] want);
    bus_read(15, 2'b10, d, ok);
    total++;
    if (d !== want) begin
      bad++;
      $display("FAIL %s status: got %h want %h", tag, d, want);
    end
  endtask

  task automatic test_reset;
    total++;
    if (uo_out !== 8'h00 || user_interrupt !== 1'b0 || data_ready !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got uo=%h irq=%b rdy=%b want 00 0 0", uo_out, user_interrupt, data_ready);
    end
    bus_read(14, 2'b10, d, ok);
    total++;
    if (d !== DEF_CFG) begin bad++; $display("FAIL reset_config: got %h want %h", d, DEF_CFG); end
    total++;
    if (!ok) begin bad++; $display("FAIL read_handshake: got ok=%b want 1", ok); end
    bus_read(14, 2'b00, d, ok);
    total++;
    if (d !== (DEF_CFG & 32'hFF)) begin bad++; $display("FAIL narrow_read: got %h want %h", d, DEF_CFG & 32'hFF); end
    check_status("reset", 32'h0);
    for (int r = 0; r < 14; r++) exp_rows[r] = '0;
    check_rows("reset");
  endtask

  task automatic test_full_frame;
    // Default horizontal timing, vertically compressed to stay short.
    set_cfg(391, 51, 2, 1);
    pix_mode = 0;
    bus_write(15, 32'h1);
    idle(4);
    run_frame(17, 2034, 244, 2);
    idle(2);
    fill_model(17, 2034);
    check_rows("full");
    check_status("full", stat(2034, 0, 1, 1, 0));
    total++;
    if (user_interrupt !== 1'b1) begin bad++; $display("FAIL full_irq: got %b want 1", user_interrupt); end
  endtask

  task automatic test_sample_timing;
    set_cfg(10, 1, 0, 1);
    pix_mode = 1;
    bus_write(15, 32'h1);
    idle(3);
    strobe_err = 0; strobe_cnt = 0; chk_strobe = 1;
    run_frame(14, 64, 8, 2);
    chk_strobe = 0;
    idle(2);
    total++;
    if (strobe_err !== 0) begin bad++; $display("FAIL strobe_timing: got %0d misplaced want 0", strobe_err); end
    total++;
    if (strobe_cnt !== 14 * 32) begin bad++; $display("FAIL strobe_count: got %0d want %0d", strobe_cnt, 14 * 32); end
    fill_model(14, 64);
    check_rows("timing");
    check_status("timing", stat(64, 0, 1, 1, 0));
  endtask

  task automatic test_truncated;
    set_cfg(0, 1, 0, 1);
    pix_mode = 2;
    pix_seed = $urandom;
    bus_write(15, 32'h1);
    idle(3);
    strobe_err = 0; strobe_cnt = 0; chk_strobe = 1;
    run_frame(15, 20, 4, 2);
    chk_strobe = 0;
    idle(2);
    total++;
    if (strobe_err !== 0 || strobe_cnt !== 14 * 20) begin
      bad++;
      $display("FAIL trunc_strobes: got err=%0d cnt=%0d want 0 %0d", strobe_err, strobe_cnt, 14 * 20);
    end
    fill_model(15, 20);
    check_rows("trunc");
    check_status("trunc", stat(20, 0, 1, 1, 0));
  endtask

  task automatic test_short_frame;
    set_cfg(5, 2, 0, 1);
    pix_mode = 2;
    pix_seed = $urandom;
    bus_write(15, 32'h1);
    idle(3);
    run_frame(5, 100, 10, 2);
    fill_model(5, 100);
    pix_seed = $urandom;
    run_frame(2, 100, 10, 2);
    idle(2);
    check_rows("short");
    check_status("short", stat(100, 1, 1, 1, 0));
    total++;
    if (user_interrupt !== 1'b1) begin bad++; $display("FAIL short_irq: got %b want 1", user_interrupt); end
    bus_write(15, 32'h4);
    check_status("clear", stat(100, 0, 1, 0, 0));
    total++;
    if (user_interrupt !== 1'b0) begin bad++; $display("FAIL clear_irq: got %b want 0", user_interrupt); end
    // Continuous: a short frame, then the next frame begins on the same vsync edge.
    bus_write(15, 32'h2);
    idle(3);
    pix_seed = $urandom;
    run_frame(5, 100, 10, 2);
    pix_seed = $urandom;
    run_frame(15, 100, 10, 2);
    fill_model(15, 100);
    check_rows("cont");
    check_status("cont", stat(100, 1, 1, 1, 1));
    pix_seed = $urandom;
    run_frame(3, 100, 10, 2);
    check_status("cont_capture", stat(100, 1, 1, 1, 1));
    bus_write(15, 32'hB);
    check_status("stop", stat(100, 1, 1, 1, 0));
  endtask

  task automatic test_stop_and_reset;
    bus_write(15, 32'h1);
    idle(3);
    pix_seed = $urandom;
    run_frame(3, 100, 10, 2);
    check_status("armed", stat(100, 0, 1, 0, 1));
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    total++;
    if (uo_out !== 8'h00 || user_interrupt !== 1'b0) begin
      bad++;
      $display("FAIL midreset_outputs: got uo=%h irq=%b want 00 0", uo_out, user_interrupt);
    end
    check_status("midreset", 32'h0);
    bus_read(14, 2'b10, d, ok);
    total++;
    if (d !== DEF_CFG) begin bad++; $display("FAIL midreset_config: got %h want %h", d, DEF_CFG); end
    for (int r = 0; r < 14; r++) exp_rows[r] = '0;
    check_rows("midreset");
  endtask

  initial begin
    rst_n = 1'b0;
    ui_in = 8'h06;
    address = '0;
    data_in = '0;
    data_write_n = 2'b11;
    data_read_n = 2'b11;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    test_reset;
    test_full_frame;
    test_sample_timing;
    test_truncated;
    test_short_frame;
    test_stop_and_reset;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
